// File: rtl/serial_to_parallel.sv
// Byte-stream to word assembler: packs received bytes MSB-first into an N-bit word
// and holds it under a valid/ready handshake until the consumer takes it.
module serial_to_parallel #(
    parameter int N          = 256,
    parameter int BYTES_LOG2 = 5,
    parameter int TIMEOUT    = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         tx_ready,
    output logic [N-1:0] tx_bytes,
    output logic         tx_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout
);

    localparam int NBYTES = 1 << BYTES_LOG2;
    localparam int CW     = BYTES_LOG2 + 1;
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] COUNT_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t         state_q,    state_d;
    logic [N-1:0]   shift_q,    shift_d;
    logic [CW-1:0]  count_q,    count_d;
    logic [TW-1:0]  timer_q,    timer_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q,     busy_d;
    logic           overrun_q,  overrun_d;
    logic           timeout_q,  timeout_d;

    // Shift works for N == 8 too, where the whole old word falls off the top.
    function automatic logic [N-1:0] shift_in(input logic [N-1:0] word, input logic [7:0] b);
        return (word << 8) | N'(b);
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        timer_d   = timer_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    shift_d = shift_in(shift_q, rx_byte);
                    timer_d = '0;
                    if (NBYTES == 1) begin
                        count_d = '0;
                        state_d = FULL;
                    end else begin
                        count_d = CW'(1);
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (rx_valid) begin
                    shift_d = shift_in(shift_q, rx_byte);
                    timer_d = '0;
                    if (count_q == COUNT_LAST) begin
                        count_d = '0;
                        state_d = FULL;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TIMER_LAST) begin
                        count_d   = '0;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            FULL: begin
                // A byte arriving on the handshake edge starts the next word.
                if (tx_valid_q && tx_ready) begin
                    if (rx_valid) begin
                        shift_d = shift_in(shift_q, rx_byte);
                        timer_d = '0;
                        if (NBYTES == 1) begin
                            count_d = '0;
                            state_d = FULL;
                        end else begin
                            count_d = CW'(1);
                            state_d = COLLECT;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_valid) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase

        tx_valid_d = (state_d == FULL);
        busy_d     = (state_d == COLLECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_bytes = shift_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed scenarios plus random traffic, checked
// against a byte-queue reference model and a word scoreboard.
module tb_serial_to_parallel;

    localparam int N  = 256;
    localparam int BL = 5;
    localparam int NB = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         tx_ready = 1'b0;
    logic [N-1:0] tx_bytes;
    logic         tx_valid;
    logic         busy;
    logic         overrun;
    logic         timeout;

    always #5 clk = ~clk;

    serial_to_parallel #(.N(N), .BYTES_LOG2(BL), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_ready (tx_ready),
        .tx_bytes (tx_bytes),
        .tx_valid (tx_valid),
        .busy     (busy),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];

    // Reference model: bytes of the word in progress, idle cycles, pending word.
    logic [7:0]   part[$];
    int           idle_cnt = 0;
    bit           pend = 1'b0;
    logic [N-1:0] pend_word = '0;
    bit           m_ov = 1'b0;
    bit           m_to = 1'b0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] pack(input logic [7:0] q[$]);
        logic [N-1:0] w = '0;
        foreach (q[i]) w = (w << 8) | N'(q[i]);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check1("rst_tx_valid", tx_valid, 1'b0);
            check1("rst_busy", busy, 1'b0);
            check1("rst_overrun", overrun, 1'b0);
            check1("rst_timeout", timeout, 1'b0);
            check("rst_tx_bytes", tx_bytes, '0);
            part.delete();
            exp_q.delete();
            idle_cnt = 0;
            pend = 1'b0;
            m_ov = 1'b0;
            m_to = 1'b0;
        end else begin
            check1("tx_valid", tx_valid, pend);
            check1("busy", busy, part.size() > 0);
            check1("overrun", overrun, m_ov);
            check1("timeout", timeout, m_to);
            if (pend) check("held_word", tx_bytes, pend_word);
            // predict the effect of the coming rising edge
            m_ov = 1'b0;
            m_to = 1'b0;
            if (pend) begin
                if (tx_ready) begin
                    pend = 1'b0;
                    if (rx_valid) begin
                        part.delete();
                        part.push_back(rx_byte);
                        idle_cnt = 0;
                    end
                end else if (rx_valid) begin
                    m_ov = 1'b1;
                end
            end else if (rx_valid) begin
                part.push_back(rx_byte);
                idle_cnt = 0;
                if (part.size() == NB) begin
                    pend = 1'b1;
                    pend_word = pack(part);
                    exp_q.push_back(pend_word);
                    part.delete();
                end
            end else if (part.size() > 0) begin
                if (idle_cnt == TO - 1) begin
                    part.delete();
                    m_to = 1'b1;
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: every handshake consumes one expected word.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected word %h, required none", tx_bytes);
            end else begin
                check("word", tx_bytes, exp_q.pop_front());
            end
        end
    end

    task automatic strobe(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [N-1:0] w6;

        repeat (3) @(posedge clk);
        #1;
        check1("reset_tx_valid", tx_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check("reset_tx_bytes", tx_bytes, '0);
        rst_n = 1'b1;

        // 1: basic word with gaps
        tx_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            strobe(8'(i));
            idle(3);
        end
        idle(5);

        // 2: backpressure and overrun
        tx_ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            strobe(8'(8'h40 + i));
            idle(1);
        end
        idle(5);
        strobe(8'hAA);
        idle(14);
        check1("hold_valid", tx_valid, 1'b1);
        tx_ready = 1'b1;
        idle(1);
        check1("release_valid", tx_valid, 1'b0);
        check1("release_busy", busy, 1'b0);

        // 3: handshake edge carries the first byte of the next word
        tx_ready = 1'b0;
        for (int i = 0; i < NB; i++) strobe(8'(8'h10 + i));
        idle(4);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h5A;
        idle(1);
        check1("accept_byte_busy", busy, 1'b1);
        check1("accept_byte_overrun", overrun, 1'b0);
        for (int i = 1; i < NB; i++) begin
            strobe(8'(i));
            idle(2);
        end
        idle(4);

        // 4: timeout after a partial word
        for (int i = 0; i < 5; i++) begin
            strobe(8'(8'hC0 + i));
            if (i < 4) idle(1);
        end
        idle(1);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (timeout) begin
                k = c;
                break;
            end
        end
        check("timeout_latency", N'(k), N'(16));
        idle(1);
        check1("timeout_busy", busy, 1'b0);
        for (int i = 0; i < NB; i++) begin
            strobe(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end
        idle(4);

        // 5: asynchronous reset in the middle of a word
        for (int i = 0; i < 10; i++) begin
            strobe(8'(8'h70 + i));
            idle(1);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check1("async_tx_valid", tx_valid, 1'b0);
        check1("async_busy", busy, 1'b0);
        check("async_tx_bytes", tx_bytes, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NB; i++) begin
            strobe(8'hFF);
            idle(1);
        end
        idle(4);

        // 6: back-to-back bytes
        w6 = '0;
        for (int i = 0; i < NB; i++) begin
            strobe(8'(8'h80 + i));
            w6 = (w6 << 8) | N'(8'h80 + i);
        end
        idle(1);
        check1("b2b_valid", tx_valid, 1'b1);
        check("b2b_word", tx_bytes, w6);
        idle(1);
        check1("b2b_valid_drop", tx_valid, 1'b0);

        // random traffic, occasional long gaps to trigger timeouts
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            tx_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) begin
                rx_valid = 1'b0;
                idle(20);
            end else begin
                rx_valid = ($urandom_range(0, 9) < 6);
                rx_byte  = 8'($urandom_range(0, 255));
            end
        end
        tx_ready = 1'b1;
        idle(40);
        check1("scoreboard_drained", exp_q.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
